systolic_feeder: RTL

Upstream input stage for the 5x5 weight-stationary systolic array. It buffers 5-lane byte vectors from the producer in a small FIFO with a valid/ready handshake. It issues one vector per cycle onto the array's five 8-bit row inputs, delaying lane k by k-1 cycles so partial sums meet the right data in each column. At frame end it inserts zero bubbles until the skew registers have drained, then pulses `done`.

---
 rtl/systolic_feeder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: FIFO-buffered operand feeder that skews five byte lanes into a 5x5 systolic array.
// Optional feature macro FEEDER_SKEW_EN: per-lane skew registers plus the FLUSH drain before `done`.

module systolic_feeder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [39:0] in_data,
    input  logic        in_last,
    output logic [7:0]  data_out1,
    output logic [7:0]  data_out2,
    output logic [7:0]  data_out3,
    output logic [7:0]  data_out4,
    output logic [7:0]  data_out5,
    output logic [4:0]  lane_valid,
    output logic        busy,
    output logic        done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    logic [39:0]   mem_data [DEPTH];
    logic          mem_last [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, empty, full;
    state_t        state, state_next;
    logic [2:0]    cnt, cnt_next;
    logic          done_next;
    logic [39:0]   s0_data;
    logic          s0_valid;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign in_ready = !full && !clear;
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE) || !empty;

    // NOTE: the storage array is deliberately not cleared; pointers and count alone define
    // which entries are live, so the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_last[wr_ptr] <= in_last;
        end
    end

    // NOTE: every clocked register uses non-blocking assignment so all flops sample
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE, STREAM: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = STREAM;
                    if (mem_last[rd_ptr]) begin
`ifdef FEEDER_SKEW_EN
                        state_next = FLUSH;
                        cnt_next   = 3'd4;
`else
                        state_next = IDLE;
                        done_next  = 1'b1;
`endif
                    end
                end
            end
            FLUSH: begin
                cnt_next = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= done_next;
        end
    end

    // Stage 0: popped vector or an all-zero bubble.
    always_ff @(posedge clk) begin
        if (clear) begin
            s0_data  <= '0;
            s0_valid <= 1'b0;
        end else begin
            s0_data  <= pop ? mem_data[rd_ptr] : '0;
            s0_valid <= pop;
        end
    end

`ifdef FEEDER_SKEW_EN
    // Each stage carries only the lanes still waiting, so lane k leaves after k-1 stages.
    logic [31:0] sk1_data;
    logic [23:0] sk2_data;
    logic [15:0] sk3_data;
    logic [7:0]  sk4_data;
    logic [4:1]  sk_valid;

    always_ff @(posedge clk) begin
        if (clear) begin
            sk1_data <= '0;
            sk2_data <= '0;
            sk3_data <= '0;
            sk4_data <= '0;
            sk_valid <= '0;
        end else begin
            sk1_data <= s0_data[39:8];
            sk2_data <= sk1_data[31:8];
            sk3_data <= sk2_data[23:8];
            sk4_data <= sk3_data[15:8];
            sk_valid <= {sk_valid[3:1], s0_valid};
        end
    end

    assign data_out1  = s0_data[7:0];
    assign data_out2  = sk1_data[7:0];
    assign data_out3  = sk2_data[7:0];
    assign data_out4  = sk3_data[7:0];
    assign data_out5  = sk4_data;
    assign lane_valid = {sk_valid, s0_valid};
`else
    assign data_out1  = s0_data[7:0];
    assign data_out2  = s0_data[15:8];
    assign data_out3  = s0_data[23:16];
    assign data_out4  = s0_data[31:24];
    assign data_out5  = s0_data[39:32];
    assign lane_valid = {5{s0_valid}};
`endif

endmodule
